// File: rtl/spi_rx_word_fifo_pkg.sv
// ---------------------------------------------------------------------------
// spi_rx_word_fifo_pkg
//   Shared constants for the SPI slave receive path: SPI mode encoding
//   (MODE0..MODE3 -> CPOL/CPHA), default word/FIFO sizes and the idle levels
//   the pin synchronisers are preset to.
// ---------------------------------------------------------------------------
package spi_rx_word_fifo_pkg;

    // Mode number is {CPOL, CPHA}, the usual SPI numbering.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam int   DEF_WORD_W = 8;
    localparam int   DEF_DEPTH  = 4;

    // Idle pin levels: CS deasserted (high), MOSI pulled high.
    localparam logic CS_IDLE = 1'b1;
    localparam logic DI_IDLE = 1'b1;

    function automatic logic mode_cpol(input spi_mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_rx_word_fifo_if.sv
// ---------------------------------------------------------------------------
// spi_rx_word_fifo_if
//   Downstream side of the SPI receive path: show-ahead word stream with
//   valid/ready, occupancy and status flags.
//   master : the receiver (drives m_data, m_valid, level, overflow, frame_err)
//   slave  : the consumer  (drives m_ready, clr_ovf)
// ---------------------------------------------------------------------------
interface spi_rx_word_fifo_if #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              clr_ovf;
    logic              frame_err;

    modport master (
        output m_data, m_valid, level, overflow, frame_err,
        input  m_ready, clr_ovf
    );

    modport slave (
        input  m_data, m_valid, level, overflow, frame_err,
        output m_ready, clr_ovf
    );

endinterface

// File: rtl/spi_rx_word_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO, WORD_W x DEPTH (DEPTH a power of two).
//   Pointers carry one extra wrap bit so full/empty need no separate counter.
//   Ports:
//     CLK, reset      clock, async active-low reset
//     push, wdata     write request / data (ignored when full unless popping)
//     pop             read request (ignored when empty)
//     rdata           head word, 0 while empty
//     empty, full     occupancy flags
//     level           words stored, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [LW-1:0]     level
);

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [WORD_W-1:0] mem [DEPTH];
    logic              do_push, do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = LW'(wr_ptr - rd_ptr);

    // A pop frees the slot this cycle, so a push into a full FIFO still
    // lands when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage has no reset; rdata is masked while empty so stale or
    // uninitialised entries never reach the output.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_rx_word_fifo.sv
// ---------------------------------------------------------------------------
// spi_rx_word_fifo
//   SPI slave receive path. SCK/CS/DI are oversampled on CLK (CLK >= 4x SCK),
//   WORD_W-bit words are deserialised in the selected CPOL/CPHA mode and bit
//   order, and completed words are queued in a show-ahead FIFO.
//   Ports:
//     CLK        system clock
//     reset      asynchronous active-low reset
//     enable     1: receiver active; 0: deserialiser idle, FIFO still drains
//     SCK,CS,DI  asynchronous SPI pins (CS active-low)
//     bus        downstream stream: m_data/m_valid/m_ready, level,
//                sticky overflow (cleared by clr_ovf), frame_err pulse
// ---------------------------------------------------------------------------
module spi_rx_word_fifo
    import spi_rx_word_fifo_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               enable,
    input  logic               SCK,
    input  logic               CS,
    input  logic               DI,
    spi_rx_word_fifo_if.master bus
);

    localparam int            CW       = $clog2(WORD_W);
    localparam int            LW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

    // ---------------------------------------------------------------
    // Pin synchronisers, preset to the idle bus so that reset release
    // never looks like an SCK edge or a CS assertion.
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, di_sync;
    logic                   sck_s, cs_s, di_s, sck_prev;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sck_sync <= {SYNC_STAGES{CPOL}};
            cs_sync  <= {SYNC_STAGES{CS_IDLE}};
            di_sync  <= {SYNC_STAGES{DI_IDLE}};
            sck_prev <= CPOL;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], DI};
            sck_prev <= sck_s;
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign di_s  = di_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it.
    logic lead_edge, trail_edge, sample_edge;

    assign lead_edge   = (sck_prev == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_prev != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;

    // ---------------------------------------------------------------
    // Deserialiser: bit counter + shift register.
    // ---------------------------------------------------------------
    logic [CW-1:0]     bit_cnt, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d, shift_in;
    logic              rx_idle, push, frame_err_d, frame_err_q;

    assign rx_idle  = cs_s | ~enable;
    assign shift_in = LSB_FIRST ? {di_s, shift_q[WORD_W-1:1]}
                                : {shift_q[WORD_W-2:0], di_s};

    always_comb begin
        bit_cnt_d   = bit_cnt;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        // Idle wins over a coincident sample edge, so the edge that races
        // a CS rise (or enable fall) is dropped along with the partial word.
        if (rx_idle) begin
            bit_cnt_d   = '0;
            shift_d     = '1;
            frame_err_d = (bit_cnt != '0);
        end else if (sample_edge) begin
            if (bit_cnt == LAST_BIT) begin
                // Final bit goes straight into the FIFO from shift_in; the
                // counter rearms so back-to-back words need no CS toggle.
                push      = 1'b1;
                bit_cnt_d = '0;
                shift_d   = '1;
            end else begin
                bit_cnt_d = bit_cnt + 1'b1;
                shift_d   = shift_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            shift_q     <= '1;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------
    // Word FIFO and overflow flag.
    // ---------------------------------------------------------------
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_empty, fifo_full, drop, overflow_q;
    logic [LW-1:0]     fifo_level;

    sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .reset  (reset),
        .push   (push),
        .wdata  (shift_in),
        .pop    (bus.m_ready),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    // Same rule the FIFO uses to accept: full with a pop still takes the word.
    assign drop = push & fifo_full & ~bus.m_ready;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.m_data    = fifo_rdata;
    assign bus.m_valid   = ~fifo_empty;
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx_word_fifo.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_word_fifo
//   Five receivers share CLK/reset/enable and each has its own SPI pins:
//   index 0..3 are SPI modes 0..3 with LSB-first, index 4 is mode 0
//   MSB-first (the main instance for FIFO and error corner cases).
// ---------------------------------------------------------------------------
module tb_spi_rx_word_fifo;

    localparam int N    = 5;
    localparam int MAIN = 4;
    localparam int HALF = 4;    // SCK half period in CLK cycles

    logic CLK    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b1;

    always #5 CLK = ~CLK;

    logic       sck_p [N];
    logic       cs_p  [N];
    logic       di_p  [N];
    logic       rdy_a [N];
    logic       clr_a [N];
    logic [7:0] dat_a [N];
    logic       vld_a [N];
    logic [2:0] lvl_a [N];
    logic       ovf_a [N];
    logic       fe_a  [N];
    int         fe_cnt [N];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_rx_word_fifo_if #(.WORD_W(8), .DEPTH(4)) bus ();

        assign bus.m_ready = rdy_a[g];
        assign bus.clr_ovf = clr_a[g];
        assign dat_a[g]    = bus.m_data;
        assign vld_a[g]    = bus.m_valid;
        assign lvl_a[g]    = bus.level;
        assign ovf_a[g]    = bus.overflow;
        assign fe_a[g]     = bus.frame_err;

        spi_rx_word_fifo #(
            .WORD_W      (8),
            .DEPTH       (4),
            .CPOL        (1'(g >> 1)),
            .CPHA        (1'(g)),
            .LSB_FIRST   (g < 4),
            .SYNC_STAGES (2)
        ) dut (
            .CLK    (CLK),
            .reset  (reset),
            .enable (enable),
            .SCK    (sck_p[g]),
            .CS     (cs_p[g]),
            .DI     (di_p[g]),
            .bus    (bus)
        );
    end

    // Counts frame_err high cycles, so a stretched pulse shows up as >1.
    always @(negedge CLK) begin
        for (int k = 0; k < N; k++)
            if (fe_a[k] === 1'b1) fe_cnt[k] <= fe_cnt[k] + 1;
    end

    function automatic logic cpol_of(input int d); return 1'(d >> 1); endfunction
    function automatic logic cpha_of(input int d); return 1'(d);      endfunction
    function automatic logic lsb_of (input int d); return d < 4;      endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Clocks out nb bits of w as an SPI master in the instance's mode.
    task automatic send_bits(input int d, input logic [7:0] w, input int nb);
        logic cpol, cpha, b;
        cpol = cpol_of(d);
        cpha = cpha_of(d);
        for (int k = 0; k < nb; k++) begin
            b = lsb_of(d) ? w[k] : w[7-k];
            if (!cpha) begin
                di_p[d] = b;  tick(HALF);
                sck_p[d] = ~cpol; tick(HALF);
                sck_p[d] = cpol;
            end else begin
                sck_p[d] = ~cpol; di_p[d] = b; tick(HALF);
                sck_p[d] = cpol;  tick(HALF);
            end
        end
    endtask

    task automatic frame(input int d, input logic [7:0] w, input int nb);
        cs_p[d] = 1'b0; tick(HALF);
        send_bits(d, w, nb);
        tick(HALF);
        cs_p[d] = 1'b1; tick(8);
    endtask

    // Main instance (mode 0, MSB first): CS low, 7 bits, then the 8th
    // leading edge is left on the pin as this returns.
    task automatic main_to_last_sample(input logic [7:0] w);
        cs_p[MAIN] = 1'b0; tick(HALF);
        send_bits(MAIN, w, 7);
        di_p[MAIN] = w[0]; tick(HALF);
        sck_p[MAIN] = 1'b1;
    endtask

    task automatic main_close_frame();
        tick(HALF);
        sck_p[MAIN] = 1'b0; tick(HALF);
        cs_p[MAIN] = 1'b1; tick(8);
    endtask

    task automatic pop(input int d);
        rdy_a[d] = 1'b1; tick(1);
        rdy_a[d] = 1'b0; tick(1);
    endtask

    typedef struct {
        int         d;
        logic [7:0] w;
        int         nb;
        logic [7:0] exp_data;
        int         exp_lvl;
        int         exp_fe;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        int         d, fe0;
        logic [7:0] exp_rd [4];

        for (int k = 0; k < N; k++) begin
            cs_p[k]  = 1'b1;
            di_p[k]  = 1'b1;
            sck_p[k] = cpol_of(k);
            rdy_a[k] = 1'b0;
            clr_a[k] = 1'b0;
        end

        // Reset state
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst%0d valid", k), 32'(vld_a[k]), 0);
            chk($sformatf("rst%0d level", k), 32'(lvl_a[k]), 0);
            chk($sformatf("rst%0d data", k),  32'(dat_a[k]), 0);
            chk($sformatf("rst%0d ovf", k),   32'(ovf_a[k]), 0);
        end
        tick(2);
        reset = 1'b1;
        tick(4);

        // Single frames: {dut, word, bits, data, level, frame_err pulses}
        vt[0]  = '{MAIN, 8'hA5, 8, 8'hA5, 1, 0};
        vt[1]  = '{0,    8'h3C, 8, 8'h3C, 1, 0};
        vt[2]  = '{1,    8'h3C, 8, 8'h3C, 1, 0};
        vt[3]  = '{2,    8'h3C, 8, 8'h3C, 1, 0};
        vt[4]  = '{3,    8'h3C, 8, 8'h3C, 1, 0};
        vt[5]  = '{MAIN, 8'h00, 8, 8'h00, 1, 0};
        vt[6]  = '{MAIN, 8'hFF, 8, 8'hFF, 1, 0};
        vt[7]  = '{0,    8'h81, 8, 8'h81, 1, 0};
        vt[8]  = '{3,    8'h5A, 8, 8'h5A, 1, 0};
        vt[9]  = '{1,    8'hFF, 3, 8'h00, 0, 1};
        vt[10] = '{2,    8'hFF, 7, 8'h00, 0, 1};

        for (int i = 0; i < NV; i++) begin
            d   = vt[i].d;
            fe0 = fe_cnt[d];
            frame(d, vt[i].w, vt[i].nb);
            chk($sformatf("v%0d level", i), 32'(lvl_a[d]), 32'(vt[i].exp_lvl));
            chk($sformatf("v%0d valid", i), 32'(vld_a[d]), 32'(vt[i].exp_lvl > 0));
            if (vt[i].exp_lvl > 0)
                chk($sformatf("v%0d data", i), 32'(dat_a[d]), 32'(vt[i].exp_data));
            chk($sformatf("v%0d frame_err", i), 32'(fe_cnt[d] - fe0), 32'(vt[i].exp_fe));
            pop(d);
            chk($sformatf("v%0d drained", i), 32'(lvl_a[d]), 0);
        end

        // Latency: 8th sample pin edge -> m_valid after 3 CLK (2 sync + 1)
        main_to_last_sample(8'hC3);
        tick(2);
        chk("lat valid early", 32'(vld_a[MAIN]), 0);
        tick(1);
        chk("lat valid", 32'(vld_a[MAIN]), 1);
        chk("lat data", 32'(dat_a[MAIN]), 32'h00C3);
        main_close_frame();
        pop(MAIN);
        chk("lat drained", 32'(lvl_a[MAIN]), 0);

        // Abort after 5 bits, then a clean 0x81
        fe0 = fe_cnt[MAIN];
        frame(MAIN, 8'hFF, 5);
        chk("abort fe", 32'(fe_cnt[MAIN] - fe0), 1);
        chk("abort level", 32'(lvl_a[MAIN]), 0);
        frame(MAIN, 8'h81, 8);
        chk("post-abort data", 32'(dat_a[MAIN]), 32'h81);
        chk("post-abort fe", 32'(fe_cnt[MAIN] - fe0), 1);
        pop(MAIN);

        // enable falling mid-word acts like CS rising
        fe0 = fe_cnt[MAIN];
        cs_p[MAIN] = 1'b0; tick(HALF);
        send_bits(MAIN, 8'hFF, 3);
        tick(HALF);
        enable = 1'b0; tick(6);
        chk("disable fe", 32'(fe_cnt[MAIN] - fe0), 1);
        chk("disable level", 32'(lvl_a[MAIN]), 0);
        cs_p[MAIN] = 1'b1; tick(4);
        enable = 1'b1; tick(4);

        // Overflow: five words into a 4-deep FIFO with no reads
        for (int w = 1; w <= 5; w++) frame(MAIN, 8'(w), 8);
        chk("ovf level", 32'(lvl_a[MAIN]), 4);
        chk("ovf flag", 32'(ovf_a[MAIN]), 1);
        for (int w = 1; w <= 4; w++) begin
            chk($sformatf("ovf read%0d", w), 32'(dat_a[MAIN]), 32'(w));
            pop(MAIN);
        end
        chk("ovf drained", 32'(lvl_a[MAIN]), 0);
        chk("ovf sticky", 32'(ovf_a[MAIN]), 1);
        clr_a[MAIN] = 1'b1; tick(1);
        clr_a[MAIN] = 1'b0; tick(1);
        chk("ovf cleared", 32'(ovf_a[MAIN]), 0);

        // Full FIFO: pop lands in the same cycle as the push of 0x77
        for (int w = 1; w <= 4; w++) frame(MAIN, 8'(w), 8);
        chk("full level", 32'(lvl_a[MAIN]), 4);
        main_to_last_sample(8'h77);
        tick(2);
        rdy_a[MAIN] = 1'b1; tick(1);
        rdy_a[MAIN] = 1'b0;
        chk("push+pop level", 32'(lvl_a[MAIN]), 4);
        chk("push+pop ovf", 32'(ovf_a[MAIN]), 0);
        main_close_frame();
        exp_rd = '{8'h02, 8'h03, 8'h04, 8'h77};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("push+pop read%0d", k), 32'(dat_a[MAIN]), 32'(exp_rd[k]));
            pop(MAIN);
        end
        chk("push+pop drained", 32'(lvl_a[MAIN]), 0);

        // Reset mid-word with two words queued
        frame(MAIN, 8'h11, 8);
        frame(MAIN, 8'h22, 8);
        chk("pre-reset level", 32'(lvl_a[MAIN]), 2);
        cs_p[MAIN] = 1'b0; tick(HALF);
        send_bits(MAIN, 8'hFF, 3);
        reset = 1'b0;
        #1;
        chk("reset level", 32'(lvl_a[MAIN]), 0);
        chk("reset valid", 32'(vld_a[MAIN]), 0);
        chk("reset data",  32'(dat_a[MAIN]), 0);
        chk("reset fe",    32'(fe_a[MAIN]), 0);
        cs_p[MAIN]  = 1'b1;
        sck_p[MAIN] = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(4);
        fe0 = fe_cnt[MAIN];
        frame(MAIN, 8'h5A, 8);
        chk("post-reset data",  32'(dat_a[MAIN]), 32'h5A);
        chk("post-reset level", 32'(lvl_a[MAIN]), 1);
        chk("post-reset fe",    32'(fe_cnt[MAIN] - fe0), 0);
        pop(MAIN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
